// File: rtl/de10_bus_pkg.sv
// Shared types and constants for the DE10 memory-bus arbiter and its address decoder.
package de10_bus_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} arb_owner_t;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   // Target tags agreed with the bus decoder.
   localparam logic [1:0] TAG_SRAM   = 2'd0;
   localparam logic [1:0] TAG_PERIPH = 2'd1;
   localparam logic [1:0] TAG_SDRAM  = 2'd2;

endpackage

// File: rtl/de10_bus_arbiter.sv
// Two-master (fetch / load-store) round-robin arbiter for the DE10 memory bus,
// with registered bus drive, one-cycle acks and a transaction watchdog.
module de10_bus_arbiter
   import de10_bus_pkg::*;
#(
   parameter int          ADDR_W  = DEF_ADDR_W,
   parameter int          DATA_W  = DEF_DATA_W,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ack,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_ack,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   output logic                bus_req,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_wstrb,
   output logic                bus_we,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ready
);

   localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);

   arb_state_t  state, state_nxt;
   arb_owner_t  owner, last_grant, pick;
   logic [15:0] wdog;
   logic        i_elig, d_elig, start, done, abort;

   // A request whose ack is showing this cycle has just been consumed.
   assign i_elig = i_req && !i_ack;
   assign d_elig = d_req && !d_ack;
   assign pick   = (d_elig && (!i_elig || last_grant == OWN_I)) ? OWN_D : OWN_I;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ARB_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (i_elig || d_elig) begin
               start     = 1'b1;
               state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (bus_ready) begin
               done      = 1'b1;
               state_nxt = ARB_IDLE;
            end else if (TIMEOUT != 0 && wdog == WDOG_LIMIT) begin
               abort     = 1'b1;
               state_nxt = ARB_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner      <= OWN_I;
         last_grant <= OWN_I;
         wdog       <= '0;
         bus_req    <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_wstrb  <= '0;
         bus_we     <= 1'b0;
         i_ack      <= 1'b0;
         i_err      <= 1'b0;
         i_rdata    <= '0;
         d_ack      <= 1'b0;
         d_err      <= 1'b0;
         d_rdata    <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         if (start) begin
            owner      <= pick;
            last_grant <= pick;
            wdog       <= '0;
            bus_req    <= 1'b1;
            if (pick == OWN_D) begin
               bus_addr  <= d_addr;
               bus_wdata <= d_wdata;
               bus_wstrb <= d_wstrb;
               bus_we    <= d_we;
            end else begin
               bus_addr  <= i_addr;
               bus_wdata <= '0;
               bus_wstrb <= '0;
               bus_we    <= 1'b0;
            end
         end else if (done || abort) begin
            bus_req <= 1'b0;
            if (owner == OWN_D) begin
               d_ack   <= 1'b1;
               d_err   <= abort;
               d_rdata <= (done && !bus_we) ? bus_rdata : '0;
            end else begin
               i_ack   <= 1'b1;
               i_err   <= abort;
               i_rdata <= done ? bus_rdata : '0;
            end
         end else if (state == ARB_BUSY) begin
            wdog <= wdog + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_de10_bus_arbiter.sv
// Randomized bench for de10_bus_arbiter against a transaction-level model of
// grant order, ack latency, watchdog abort and returned data.
module tb_de10_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW/8;
   localparam int TO = 8;

   logic          clk = 1'b0, rst = 1'b0;
   logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [DW-1:0] d_wdata = '0, bus_rdata = '0;
   logic [SW-1:0] d_wstrb = '0;
   logic          bus_ready = 1'b0;
   logic          i_ack, i_err, d_ack, d_err, bus_req, bus_we;
   logic [DW-1:0] i_rdata, d_rdata, bus_wdata;
   logic [AW-1:0] bus_addr;
   logic [SW-1:0] bus_wstrb;

   int n_cmp = 0, n_bad = 0;
   bit last_d;
   logic [DW-1:0] m_irdata, m_drdata;
   logic          m_ierr, m_derr;

   de10_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_we(bus_we), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge where the grant for this master should be visible.
   // w = cycles bus_ready stays low after bus_req rises.
   task automatic serve(input bit is_d, input int w, input logic [DW-1:0] rdv);
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd, rd;
      logic [SW-1:0] es;
      logic          ewe;
      int            kack;
      ea   = is_d ? d_addr : i_addr;
      ewe  = is_d && d_we;
      ewd  = d_wdata;
      es   = is_d ? d_wstrb : '0;
      rd   = '0;
      kack = (w <= TO) ? w + 1 : TO + 1;
      for (int k = 0; k < kack; k++) begin
         chk("bus_req", bus_req, 1);
         chk("bus_addr", bus_addr, ea);
         chk("bus_we_strb", {bus_we, bus_wstrb}, {ewe, es});
         if (is_d) chk("bus_wdata", bus_wdata, ewd);
         chk("no_ack", {i_ack, d_ack}, 0);
         bus_ready = (k >= w);
         bus_rdata = (k == w) ? rdv : DW'($urandom);
         if (k == w) rd = rdv;
         if (k == 0 && $urandom_range(3) == 0) begin
            if (is_d) begin d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; end
            else begin i_req = 1'b0; i_addr = $urandom; end
         end
         @(negedge clk);
      end
      chk("ack_port", {i_ack, d_ack}, is_d ? 2'b01 : 2'b10);
      chk("bus_req_end", bus_req, 0);
      if (is_d) begin
         m_drdata = (w <= TO && !ewe) ? rd : '0;
         m_derr   = (w > TO);
         d_req    = 1'b0;
      end else begin
         m_irdata = (w <= TO) ? rd : '0;
         m_ierr   = (w > TO);
         i_req    = 1'b0;
      end
      chk("i_rdata", i_rdata, m_irdata);
      chk("i_err", i_err, m_ierr);
      chk("d_rdata", d_rdata, m_drdata);
      chk("d_err", d_err, m_derr);
      last_d    = is_d;
      bus_ready = 1'($urandom_range(1));
   endtask

   task automatic round(input bit ri, input bit rq, input int wi, input int wq,
                        input logic [AW-1:0] ia, input logic [AW-1:0] da, input bit we,
                        input logic [DW-1:0] wdat, input logic [SW-1:0] st,
                        input logic [DW-1:0] rdv);
      bit first_d;
      i_req = ri; d_req = rq; i_addr = ia; d_addr = da;
      d_we = we; d_wdata = wdat; d_wstrb = st;
      @(negedge clk);
      if (ri && rq) begin
         first_d = !last_d;
         serve(first_d, first_d ? wq : wi, rdv);
         @(negedge clk);
         serve(!first_d, first_d ? wi : wq, ~rdv);
      end else begin
         serve(rq, rq ? wq : wi, rdv);
      end
      repeat (1 + $urandom_range(2)) begin
         @(negedge clk);
         chk("idle_bus_req", bus_req, 0);
         chk("idle_ack", {i_ack, d_ack}, 0);
         bus_ready = 1'($urandom_range(1));
      end
   endtask

   initial begin
      bit ri, rq;
      last_d = 1'b0;
      m_irdata = '0; m_drdata = '0; m_ierr = 1'b0; m_derr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_port", {i_ack, i_err, i_rdata, d_ack, d_err, d_rdata}, 0);
      chk("rst_bus", {bus_req, bus_addr, bus_wdata, bus_wstrb, bus_we}, 0);
      rst = 1'b1;

      // contention straight out of reset, then again
      round(1, 1, 0, 0, 32'h100, 32'h0040_0000, 1'b0, '0, '0, $urandom);
      round(1, 1, 1, 2, 32'h104, 32'h0040_0004, 1'b0, '0, '0, $urandom);
      // single fetch, minimum latency
      round(1, 0, 0, 0, 32'h40, '0, 1'b0, '0, '0, 32'hDEAD_BEEF);
      // write with four wait states
      round(0, 1, 0, 4, '0, 32'h0000_2000, 1'b1, 32'h1234_5678, 4'h3, $urandom);
      // timeout, then a normal read
      round(0, 1, 0, 20, '0, 32'h0000_3000, 1'b0, '0, '0, $urandom);
      round(0, 1, 0, 1, '0, 32'h0000_3004, 1'b0, '0, '0, 32'hCAFE_F00D);

      // reset in the middle of a busy transaction
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000; i_req = 1'b0;
      bus_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", bus_req, 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_port", {i_ack, i_err, i_rdata, d_ack, d_err, d_rdata}, 0);
      chk("mid_rst_bus", {bus_req, bus_addr, bus_wdata, bus_wstrb, bus_we}, 0);
      d_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      last_d = 1'b0;
      m_irdata = '0; m_drdata = '0; m_ierr = 1'b0; m_derr = 1'b0;
      repeat (TO + 4) begin
         @(negedge clk);
         chk("post_rst_quiet", {bus_req, i_ack, d_ack}, 0);
      end
      round(0, 1, 0, 0, '0, 32'h0000_5000, 1'b0, '0, '0, $urandom);

      for (int n = 0; n < 150; n++) begin
         ri = 1'($urandom_range(1));
         rq = 1'($urandom_range(1));
         if (!ri && !rq) rq = 1'b1;
         round(ri, rq, $urandom_range(11), $urandom_range(11), $urandom, $urandom,
               1'($urandom_range(1)), $urandom, SW'($urandom), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
